// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready on both sides.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for op 11.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int OPW   = 6,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic [OPW-1:0]   alu_control,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic [TAGW-1:0]  out_tag
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_STR = OPW'(3);
  localparam logic [OPW-1:0] OP_LDR = OPW'(4);
  localparam logic [OPW-1:0] OP_MOV = OPW'(5);
  localparam logic [OPW-1:0] OP_SLL = OPW'(6);
  localparam logic [OPW-1:0] OP_SRL = OPW'(7);
  localparam logic [OPW-1:0] OP_AND = OPW'(8);
  localparam logic [OPW-1:0] OP_OR  = OPW'(9);
  localparam logic [OPW-1:0] OP_SLT = OPW'(10);

  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   sum_bi;
  logic [WIDTH:0]   sum_ai;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res_c;
  logic             cy_c;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  logic [TAGW-1:0]  mul_tag;

  assign sum_ab = {1'b0, a} + {1'b0, b};
  assign sum_bi = {1'b0, b} + {1'b0, imm};
  assign sum_ai = {1'b0, a} + {1'b0, imm};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign sh     = b[SHW-1:0];
  assign accept = in_valid && in_ready;

  // single-cycle result and flag; unknown opcodes (and op 11 without
  // the multiplier) fall through to ADD
  always_comb begin
    res_c = sum_ab[WIDTH-1:0];
    cy_c  = sum_ab[WIDTH];
    case (alu_control)
      OP_NOP: begin res_c = '0; cy_c = 1'b0; end
      OP_ADD: ;
      OP_SUB: begin res_c = diff[WIDTH-1:0]; cy_c = !diff[WIDTH]; end
      OP_STR: begin res_c = sum_bi[WIDTH-1:0]; cy_c = sum_bi[WIDTH]; end
      OP_LDR: begin res_c = sum_ai[WIDTH-1:0]; cy_c = sum_ai[WIDTH]; end
      OP_MOV: begin res_c = a; cy_c = 1'b0; end
      OP_SLL: begin res_c = a << sh; cy_c = 1'b0; end
      OP_SRL: begin res_c = a >> sh; cy_c = 1'b0; end
      OP_AND: begin res_c = a & b; cy_c = 1'b0; end
      OP_OR:  begin res_c = a | b; cy_c = 1'b0; end
      OP_SLT: begin
        res_c = WIDTH'($signed(a) < $signed(b));
        cy_c  = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [OPW-1:0] OP_MUL = OPW'(11);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    step;

  assign is_mul  = (alu_control == OP_MUL);
  assign mul_res = acc;

  // next state, handshake and multiply completion
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mul_done = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && is_mul) state_nx = S_MUL;
      end
      S_MUL: begin
        if (step == CW'(WIDTH)) begin
          mul_done = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // shift-add multiplier, one multiplier bit per step
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      step    <= '0;
      mul_tag <= '0;
    end else if (accept && is_mul) begin
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
      step    <= '0;
      mul_tag <= in_tag;
    end else if (state == S_MUL && step != CW'(WIDTH)) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + CW'(1);
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_tag  = '0;
  assign in_ready = !out_valid || out_ready;
`endif

  // output register: result, flags and tag move together
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      out_tag   <= '0;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_res;
      zero      <= (mul_res == '0);
      carry     <= 1'b0;
      out_tag   <= mul_tag;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= res_c;
      zero      <= (res_c == '0);
      carry     <= cy_c;
      out_tag   <= in_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, parametrised ALU with valid/ready handshakes on both sides, replacing the purely combinational execute-stage ALU in the RISC CPU datapath. It keeps the existing opcode map for NOP/ADD/SUB/STORE/LOAD and adds move, shift, logic and set-less-than operations. It also adds zero/carry flags, a destination tag carried through with the result, and an optional iterative multiplier. It sits between decode/register-read and writeback/memory-address generation.

## Interface
- `WIDTH`, 32: operand and result width; power of two, ≥ 8.
- `OPW`, 6: opcode width.
- `TAGW`, 5: destination-register tag width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request this cycle.
- `a`, `b`, `imm`  in  WIDTH  operands.
- `alu_control`  in  OPW  opcode.
- `in_tag`  in  TAGW  destination tag.
- `out_valid`  out  1  result held on outputs.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result == 0`.
- `carry`  out  1  carry or no-borrow flag.
- `out_tag`  out  TAGW  tag of the request that produced `result`.

## Operation
- Opcodes, with `sh = b[log2(WIDTH)-1:0]`:
  - 0 NOP: `result = 0`.
  - 1 ADD: `a+b`.
  - 2 SUB: `a-b`.
  - 3 STORE: `b+imm`.
  - 4 LOAD: `a+imm`.
  - 5 MOV: `a`.
  - 6 SLL: `a<<sh`.
  - 7 SRL: `a>>sh` (logical).
  - 8 AND: `a&b`.
  - 9 OR: `a|b`.
  - 10 SLT: signed `a<b` gives 1, else 0.
  - 11 MUL: low WIDTH bits of `a*b`, unsigned.
  - Any other opcode: ADD.
- All arithmetic is modulo 2^WIDTH.
- `carry`:
  - ADD, STORE, LOAD: bit WIDTH of the WIDTH+1-bit sum.
  - SUB: 1 when `a >= b` unsigned.
  - All other ops: 0.
- FSM states:
  - IDLE: accepting. `in_ready = !out_valid || out_ready`.
  - MUL: iterative shift-add, one multiplier bit per cycle, WIDTH cycles. `in_ready = 0`.
- Transitions:
  - IDLE→IDLE on accept of a single-cycle op. The result register loads with `out_valid = 1`.
  - IDLE→MUL on accept of op 11. Operands and tag are latched. `out_valid` drops if the previous result was consumed that cycle.
  - MUL→IDLE after the WIDTH-th step. The product is written to `result` with `out_valid = 1`.
- Output holding:
  - While `out_valid && !out_ready`, `result`, `zero`, `carry` and `out_tag` hold stable and `in_ready = 0`.
  - When `out_valid && !out_ready` and no new accept occurs, `out_valid` clears on the cycle after `out_ready` is seen high.
- Simultaneous consume and accept in IDLE: the new result replaces the old one in the same edge. There is no bubble.
- `in_valid` with `in_ready = 0`: the request is ignored. The producer holds it.
- `zero` and `carry` are registered together with `result`, never combinational from the inputs.

## Timing
- Reset, including mid-MUL:
  - State goes to IDLE and any multiply is aborted with no output.
  - `out_valid = 0`, `result = 0`, `zero = 1`, `carry = 0`, `out_tag = 0`.
  - `in_ready = 1` on the first cycle after reset deasserts.
- Latency:
  - Single-cycle ops: result valid 1 cycle after accept.
  - MUL: result valid WIDTH+1 cycles after accept.
- Throughput: one single-cycle op per clock while `out_ready = 1`. MUL blocks new accepts for WIDTH+1 cycles.
- Multiply step counter is log2(WIDTH)+1 bits and resets to 0 on each MUL accept.
- Shift amounts ≥ WIDTH are impossible by construction; only the low bits of `b` are used.

## Configuration
- `ALU_MUL_EN` defined:
  - Op 11 performs the iterative multiply.
  - MUL state, multiplicand/multiplier/accumulator registers and step counter are present.
- `ALU_MUL_EN` undefined:
  - Op 11 takes the default path (ADD, single cycle).
  - No MUL state or multiply registers are synthesised.
  - `in_ready` depends only on output occupancy.

## Test plan
- Reset: hold `reset` 2 cycles → `out_valid = 0`, `result = 0`, `zero = 1`, `carry = 0`. Then `in_ready = 1`.
- Back-to-back with `out_ready = 1`: ADD `a=0xFFFFFFFF`, `b=1` → `result = 0`, `zero = 1`, `carry = 1` next cycle. Following cycle, SUB `a=5`, `b=7` → `0xFFFFFFFE`, `carry = 0`.
- Opcode sweep:
  - STORE `b=0x100`, `imm=4` → `0x104`; LOAD `a=0x200`, `imm=8` → `0x208`.
  - SLL `a=1`, `b=0x25` → `0x20` (sh = 5).
  - SLT `a=0x80000000`, `b=1` → 1.
  - Opcode 63 with `a=2`, `b=3` → 5.
- Backpressure: `out_ready = 0` for 4 cycles with `in_valid` held → `in_ready = 0` and outputs stable. On `out_ready = 1`, the next op is accepted in the same cycle and the new `out_tag` appears next cycle.
- MUL (`ALU_MUL_EN`): `a=1234`, `b=5678`, tag 7 → `out_valid` exactly 33 cycles after accept, `result = 7006652`, `out_tag = 7`. Without the macro → `result = 6912` after 1 cycle.
- Reset assertion at MUL step 10 → no `out_valid`. Next accepted ADD returns correctly after 1 cycle.
